// File: rtl/host_mem_rd_burst_arbiter.sv
// Round-robin burst arbiter that shares one Avalon host read port among NUM_REQ engines, with credit-limited outstanding beats and in-order response steering.
// Optional per-requester grant counters are enabled by defining HOST_MEM_RD_ARB_STATS_EN.
module host_mem_rd_burst_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 42,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int MAX_BEATS       = 256,
  parameter int ORDER_DEPTH     = 32
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 req_read,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_address,
  input  logic [NUM_REQ*BURST_CNT_WIDTH-1:0] req_burstcount,
  output logic [NUM_REQ-1:0]                 req_waitrequest,
  output logic [NUM_REQ-1:0]                 rsp_readdatavalid,
  output logic [DATA_WIDTH-1:0]              rsp_readdata,
  output logic                               host_read,
  output logic [ADDR_WIDTH-1:0]              host_address,
  output logic [BURST_CNT_WIDTH-1:0]         host_burstcount,
  input  logic                               host_waitrequest,
  input  logic                               host_readdatavalid,
  input  logic [DATA_WIDTH-1:0]              host_readdata,
  output logic                               err_unexpected_rsp,
  output logic                               err_zero_burst,
  output logic [NUM_REQ*32-1:0]              grant_cnt
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(MAX_BEATS + 1);
  localparam int PW  = (ORDER_DEPTH > 1) ? $clog2(ORDER_DEPTH) : 1;
  localparam int OCW = $clog2(ORDER_DEPTH + 1);
  localparam int BW  = BURST_CNT_WIDTH;
  localparam int AW  = ADDR_WIDTH;

  logic                  host_read_q, host_read_d;
  logic [AW-1:0]         host_address_q, host_address_d;
  logic [BW-1:0]         host_bc_q, host_bc_d;
  logic [NUM_REQ-1:0]    rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  err_unexp_q, err_unexp_d;
  logic                  err_zero_q, err_zero_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [OCW-1:0]        ord_cnt_q, ord_cnt_d;
  logic [IDW-1:0]        ord_id_q [ORDER_DEPTH];
  logic [BW-1:0]         ord_bc_q [ORDER_DEPTH];

  logic                  slot_free, ord_full, ord_empty;
  logic                  grant_vld, push, pop, beat_acc;
  logic [NUM_REQ-1:0]    grant;
  logic [IDW-1:0]        grant_idx;
  logic [BW-1:0]         grant_bc;
  logic [AW-1:0]         grant_addr;
  logic [IDW-1:0]        head_id;
  logic [BW-1:0]         head_bc;

  assign slot_free = !host_read_q || !host_waitrequest;
  assign ord_full  = (ord_cnt_q == OCW'(ORDER_DEPTH));
  assign ord_empty = (ord_cnt_q == '0);
  assign head_id   = ord_id_q[rd_ptr_q];
  assign head_bc   = ord_bc_q[rd_ptr_q];

  // Scan starts just after the last winner so every requester gets a turn per round.
  always_comb begin
    grant      = '0;
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_bc   = '0;
    grant_addr = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_vld && req_read[idx] && slot_free && !ord_full &&
          int'(req_burstcount[idx*BW +: BW]) <= int'(credits_q)) begin
        grant_vld   = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = IDW'(idx);
        grant_bc    = req_burstcount[idx*BW +: BW];
        grant_addr  = req_address[idx*AW +: AW];
      end
    end
  end

  always_comb begin
    host_read_d    = host_read_q;
    host_address_d = host_address_q;
    host_bc_d      = host_bc_q;
    rr_ptr_d       = rr_ptr_q;
    rsp_vld_d      = '0;
    rsp_data_d     = rsp_data_q;
    err_unexp_d    = err_unexp_q;
    err_zero_d     = err_zero_q;
    beat_cnt_d     = beat_cnt_q;
    push           = 1'b0;
    pop            = 1'b0;
    beat_acc       = 1'b0;
    if (slot_free) host_read_d = 1'b0;
    if (grant_vld) begin
      rr_ptr_d = grant_idx;
      // Zero-length requests are acknowledged but never reach the host.
      if (grant_bc == '0) begin
        err_zero_d = 1'b1;
      end else begin
        host_read_d    = 1'b1;
        host_address_d = grant_addr;
        host_bc_d      = grant_bc;
        push           = 1'b1;
      end
    end
    if (host_readdatavalid) begin
      if (ord_empty) begin
        err_unexp_d = 1'b1;
      end else begin
        beat_acc           = 1'b1;
        rsp_vld_d[head_id] = 1'b1;
        rsp_data_d         = host_readdata;
        if (beat_cnt_q + BW'(1) == head_bc) begin
          pop        = 1'b1;
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
    end
    credits_d = credits_q - (push ? CW'(grant_bc) : CW'(0)) + (beat_acc ? CW'(1) : CW'(0));
    ord_cnt_d = ord_cnt_q + OCW'(push) - OCW'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_read_q    <= 1'b0;
      host_address_q <= '0;
      host_bc_q      <= '0;
      rsp_vld_q      <= '0;
      rsp_data_q     <= '0;
      err_unexp_q    <= 1'b0;
      err_zero_q     <= 1'b0;
      credits_q      <= CW'(MAX_BEATS);
      beat_cnt_q     <= '0;
      rr_ptr_q       <= IDW'(NUM_REQ - 1);
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      ord_cnt_q      <= '0;
    end else begin
      host_read_q    <= host_read_d;
      host_address_q <= host_address_d;
      host_bc_q      <= host_bc_d;
      rsp_vld_q      <= rsp_vld_d;
      rsp_data_q     <= rsp_data_d;
      err_unexp_q    <= err_unexp_d;
      err_zero_q     <= err_zero_d;
      credits_q      <= credits_d;
      beat_cnt_q     <= beat_cnt_d;
      rr_ptr_q       <= rr_ptr_d;
      ord_cnt_q      <= ord_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ord_id_q[wr_ptr_q] <= grant_idx;
      ord_bc_q[wr_ptr_q] <= grant_bc;
    end
  end

`ifdef HOST_MEM_RD_ARB_STATS_EN
  logic [31:0] gcnt_q [NUM_REQ];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
    end else if (push) begin
      gcnt_q[grant_idx] <= gcnt_q[grant_idx] + 32'd1;
    end
  end
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    assign grant_cnt[i*32 +: 32] = gcnt_q[i];
  end
`else
  assign grant_cnt = '0;
`endif

  assign req_waitrequest    = reset_n ? ~grant : '1;
  assign rsp_readdatavalid  = rsp_vld_q;
  assign rsp_readdata       = rsp_data_q;
  assign host_read          = host_read_q;
  assign host_address       = host_address_q;
  assign host_burstcount    = host_bc_q;
  assign err_unexpected_rsp = err_unexp_q;
  assign err_zero_burst     = err_zero_q;
endmodule

// File: tb/tb_host_mem_rd_burst_arbiter.sv
// Bench for host_mem_rd_burst_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_host_mem_rd_burst_arbiter;
  localparam int N  = 4;
  localparam int AW = 42;
  localparam int DW = 512;
  localparam int BW = 7;
  localparam int MB = 256;
  localparam int OD = 32;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_read = '0;
  logic [N*AW-1:0] req_address = '0;
  logic [N*BW-1:0] req_burstcount = '0;
  logic [N-1:0]    req_waitrequest, rsp_readdatavalid;
  logic [DW-1:0]   rsp_readdata;
  logic            host_read;
  logic [AW-1:0]   host_address;
  logic [BW-1:0]   host_burstcount;
  logic            host_waitrequest = 1'b0;
  logic            host_readdatavalid = 1'b0;
  logic [DW-1:0]   host_readdata = '0;
  logic            err_unexpected_rsp, err_zero_burst;
  logic [N*32-1:0] grant_cnt;

  always #5 clk = ~clk;

  host_mem_rd_burst_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req_read(req_read), .req_address(req_address), .req_burstcount(req_burstcount),
    .req_waitrequest(req_waitrequest), .rsp_readdatavalid(rsp_readdatavalid), .rsp_readdata(rsp_readdata),
    .host_read(host_read), .host_address(host_address), .host_burstcount(host_burstcount),
    .host_waitrequest(host_waitrequest), .host_readdatavalid(host_readdatavalid), .host_readdata(host_readdata),
    .err_unexpected_rsp(err_unexpected_rsp), .err_zero_burst(err_zero_burst), .grant_cnt(grant_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state
  int          m_cred, m_rr, m_beat;
  int          oq_id[$];
  int          oq_len[$];
  logic        m_hread;
  logic [AW-1:0] m_haddr;
  logic [BW-1:0] m_hbc;
  logic [N-1:0]  m_rvld;
  logic [DW-1:0] m_rdata;
  logic        m_eu, m_ez;
  int unsigned m_gc[N];
  int          obs_rsp[N];
  int          glog[$];
  int          acc_len = 0;

  // Host emulation controls
  int wr_pct = 0;
  int rv_pct = 0;
  int inj_req = 0;
  int inj_done = 0;
  int host_q[$];

  function automatic logic [31:0] exp_gc(input int i);
`ifdef HOST_MEM_RD_ARB_STATS_EN
    return m_gc[i];
`else
    return 32'd0;
`endif
  endfunction

  // Compare process: checks every cycle, then advances the model.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      chk("rst_waitreq", req_waitrequest, {N{1'b1}});
      chk("rst_host_read", host_read, 1'b0);
      chk("rst_rsp_vld", rsp_readdatavalid, '0);
      chk("rst_err_unexp", err_unexpected_rsp, 1'b0);
      chk("rst_err_zero", err_zero_burst, 1'b0);
      chk("rst_grant_cnt", grant_cnt, '0);
      m_cred = MB; m_rr = N - 1; m_beat = 0;
      oq_id.delete(); oq_len.delete(); glog.delete();
      m_hread = 1'b0; m_haddr = '0; m_hbc = '0; m_rvld = '0; m_rdata = '0;
      m_eu = 1'b0; m_ez = 1'b0; acc_len = 0;
      for (int i = 0; i < N; i++) begin m_gc[i] = 0; obs_rsp[i] = 0; end
    end else begin
      int g;
      int bc;
      logic slot;
      logic [N-1:0] exp_wr;
      chk("host_read", host_read, m_hread);
      if (m_hread) begin
        chk("host_address", host_address, m_haddr);
        chk("host_burstcount", host_burstcount, m_hbc);
      end
      chk("rsp_vld", rsp_readdatavalid, m_rvld);
      if (m_rvld != '0) chk("rsp_data", rsp_readdata, m_rdata);
      chk("err_unexp", err_unexpected_rsp, m_eu);
      chk("err_zero", err_zero_burst, m_ez);
      for (int i = 0; i < N; i++) begin
        chk("grant_cnt", grant_cnt[i*32 +: 32], exp_gc(i));
        if (rsp_readdatavalid[i]) obs_rsp[i]++;
      end
      slot = !m_hread || !host_waitrequest;
      g = -1;
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (g < 0 && req_read[i] && slot && oq_id.size() < OD &&
            int'(req_burstcount[i*BW +: BW]) <= m_cred) g = i;
      end
      exp_wr = {N{1'b1}};
      if (g >= 0) exp_wr[g] = 1'b0;
      chk("req_waitreq", req_waitrequest, exp_wr);
      acc_len = (m_hread && !host_waitrequest) ? int'(m_hbc) : 0;
      m_rvld = '0;
      if (host_readdatavalid) begin
        if (oq_id.size() == 0) m_eu = 1'b1;
        else begin
          m_rvld[oq_id[0]] = 1'b1;
          m_rdata = host_readdata;
          m_beat++;
          m_cred++;
          if (m_beat == oq_len[0]) begin
            m_beat = 0;
            void'(oq_id.pop_front());
            void'(oq_len.pop_front());
          end
        end
      end
      if (slot) m_hread = 1'b0;
      if (g >= 0) begin
        m_rr = g;
        glog.push_back(g);
        bc = int'(req_burstcount[g*BW +: BW]);
        if (bc == 0) m_ez = 1'b1;
        else begin
          m_hread = 1'b1;
          m_haddr = req_address[g*AW +: AW];
          m_hbc   = BW'(bc);
          oq_id.push_back(g);
          oq_len.push_back(bc);
          m_cred -= bc;
          m_gc[g]++;
        end
      end
    end
  end

  // Host memory emulation: stalls and returns beats for accepted bursts in order.
  initial forever begin
    @(posedge clk);
    #1;
    if (!reset_n) begin
      host_q.delete();
      host_readdatavalid = 1'b0;
      host_waitrequest = 1'b0;
    end else begin
      if (acc_len > 0) host_q.push_back(acc_len);
      host_waitrequest = ($urandom_range(99) < wr_pct);
      host_readdatavalid = 1'b0;
      if (inj_req != inj_done) begin
        inj_done++;
        host_readdatavalid = 1'b1;
        for (int k = 0; k < DW / 32; k++) host_readdata[k*32 +: 32] = $urandom;
      end else if (host_q.size() > 0 && $urandom_range(99) < rv_pct) begin
        host_readdatavalid = 1'b1;
        for (int k = 0; k < DW / 32; k++) host_readdata[k*32 +: 32] = $urandom;
        host_q[0] = host_q[0] - 1;
        if (host_q[0] == 0) void'(host_q.pop_front());
      end
    end
  end

  task automatic cyc(); @(posedge clk); #2; endtask
  task automatic mid(); @(negedge clk); #2; endtask

  task automatic set_req(input int i, input bit r, input int bc, input logic [AW-1:0] a);
    req_read[i] = r;
    req_burstcount[i*BW +: BW] = BW'(bc);
    req_address[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    cyc();
    reset_n = 1'b0;
    req_read = '0;
    mid();
    chk("reset_waitreq_lit", req_waitrequest, 4'hF);
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (2) cyc();
    reset_n = 1'b1;
    mid();
    chk("idle_host_read", host_read, 1'b0);
    chk("idle_err", {err_unexpected_rsp, err_zero_burst}, 2'b00);

    // Single requester 1, burst 4
    cyc(); set_req(1, 1'b1, 4, 42'h123);
    mid(); chk("s1_waitreq", req_waitrequest, 4'b1101);
    cyc(); req_read = '0;
    mid();
    chk("s1_host_read", host_read, 1'b1);
    chk("s1_host_addr", host_address, 42'h123);
    chk("s1_host_bc", host_burstcount, 7'd4);
    rv_pct = 100;
    repeat (12) cyc();
    mid();
    chk("s1_req1_beats", obs_rsp[1], 4);
    chk("s1_other_beats", obs_rsp[0] + obs_rsp[2] + obs_rsp[3], 0);
    chk("s1_credits", m_cred, 256);

    // All four requesting burst 1: strict rotation
    do_reset();
    cyc();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1, AW'(64'h1000 + i));
    repeat (8) cyc();
    req_read = '0;
    repeat (20) cyc();
    mid();
    chk("s2_ngrants", glog.size(), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++) chk("s2_grant_order", glog[k], k % 4);
    for (int i = 0; i < N; i++) chk("s2_beats", obs_rsp[i], 2);

    // Credit exhaustion: four 64-beat bursts hold the whole pool
    do_reset();
    rv_pct = 0;
    cyc(); set_req(0, 1'b1, 64, 42'h2000);
    repeat (4) cyc();
    req_read[0] = 1'b0;
    set_req(1, 1'b1, 1, 42'h3000);
    mid();
    chk("s3_credits_zero", m_cred, 0);
    chk("s3_req1_blocked", req_waitrequest[1], 1'b1);
    rv_pct = 100;
    cyc(); rv_pct = 0;
    mid(); chk("s3_req1_blocked_beat", req_waitrequest[1], 1'b1);
    cyc();
    mid(); chk("s3_req1_granted", req_waitrequest[1], 1'b0);
    cyc(); req_read = '0;
    rv_pct = 100;
    repeat (300) cyc();
    mid();
    chk("s3_req0_beats", obs_rsp[0], 256);
    chk("s3_req1_beats", obs_rsp[1], 1);
    chk("s3_credits_back", m_cred, 256);

    // Host stall holds the request and blocks all grants
    do_reset();
    rv_pct = 0;
    wr_pct = 100;
    cyc(); set_req(0, 1'b1, 2, 42'h4444);
    mid(); chk("s4_first_grant", req_waitrequest, 4'b1110);
    cyc(); req_read[0] = 1'b0; set_req(1, 1'b1, 3, 42'h5555);
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("s4_stall_read", host_read, 1'b1);
      chk("s4_stall_addr", host_address, 42'h4444);
      chk("s4_stall_bc", host_burstcount, 7'd2);
      chk("s4_stall_waitreq", req_waitrequest, 4'hF);
      if (k < 4) cyc();
    end
    wr_pct = 0;
    cyc();
    mid(); chk("s4_release_grant", req_waitrequest, 4'b1101);
    cyc(); req_read = '0;
    mid(); chk("s4_next_addr", host_address, 42'h5555);
    rv_pct = 100;
    repeat (20) cyc();

    // Unexpected beat, then zero-length burst
    do_reset();
    rv_pct = 0;
    mid(); inj_req++;
    cyc(); cyc();
    mid();
    chk("s5_err_unexp", err_unexpected_rsp, 1'b1);
    chk("s5_no_rsp", rsp_readdatavalid, 4'b0000);
    cyc(); set_req(2, 1'b1, 0, 42'h6000);
    mid(); chk("s5_zero_accept", req_waitrequest, 4'b1011);
    cyc(); req_read = '0;
    mid();
    chk("s5_zero_no_read", host_read, 1'b0);
    chk("s5_err_zero", err_zero_burst, 1'b1);

    // Grant counters: requester 2 issues bursts of 1, 2, 4
    do_reset();
    cyc(); set_req(2, 1'b1, 1, 42'h7000);
    cyc(); set_req(2, 1'b1, 2, 42'h7100);
    cyc(); set_req(2, 1'b1, 4, 42'h7200);
    cyc(); req_read = '0;
    mid();
`ifdef HOST_MEM_RD_ARB_STATS_EN
    chk("s6_gcnt2", grant_cnt[2*32 +: 32], 32'd3);
`else
    chk("s6_gcnt2", grant_cnt[2*32 +: 32], 32'd0);
`endif
    chk("s6_gcnt_others", {grant_cnt[3*32 +: 32], grant_cnt[1*32 +: 32], grant_cnt[0 +: 32]}, '0);
    rv_pct = 100;
    repeat (20) cyc();

    // Randomized traffic with a mid-run reset
    wr_pct = 30;
    rv_pct = 60;
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        do_reset();
      end else begin
        cyc();
        for (int i = 0; i < N; i++) begin
          int r;
          int bc;
          r = $urandom_range(99);
          if (r < 3) bc = 0;
          else if (r < 15) bc = 64;
          else bc = $urandom_range(8, 1);
          set_req(i, ($urandom_range(1) == 1), bc, {$urandom, $urandom} & 64'h3FF_FFFF_FFFF);
        end
      end
    end
    cyc(); req_read = '0;
    wr_pct = 0;
    rv_pct = 100;
    repeat (600) cyc();
    mid();
    chk("final_credits", m_cred, 256);
    chk("final_order_empty", oq_id.size(), 0);
    chk("final_host_idle", host_read, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
